// File: rtl/ieeedrv_trkload_if.sv
// ieeedrv_trkload_if: SD block transfer handshake between track loader and SD host
interface ieeedrv_trkload_if #(
    parameter int SUBDRV = 2
);
    logic [31:0]       sd_lba;
    logic [5:0]        sd_blk_cnt;
    logic [SUBDRV-1:0] sd_rd;
    logic [SUBDRV-1:0] sd_wr;
    logic [SUBDRV-1:0] sd_ack;
    modport master (output sd_lba, sd_blk_cnt, sd_rd, sd_wr, input sd_ack);
    modport slave (input sd_lba, sd_blk_cnt, sd_rd, sd_wr, output sd_ack);
endinterface

// File: rtl/ieeedrv_trkload.sv
// ieeedrv_trkload: loads/writes back one track of a D64/D80/D82 image into the track buffer
module ieeedrv_trkload #(
    parameter int SUBDRV = 2
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              drv_type,
    input  logic              drv_hd,
    input  logic              drv_act,
    input  logic [7:0]        track,
    input  logic              mtr,
    input  logic              wprot,
    input  logic              buf_we,
    input  logic [SUBDRV-1:0] img_mounted,
    input  logic [31:0]       img_size,
    ieeedrv_trkload_if.master sd,
    output logic              loaded,
    output logic              invalid,
    output logic              busy
);
    typedef enum logic [2:0] {IDLE, CALC, CHECK, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, INVALID} state_t;

    // Sectors on a track; the second 8250 side repeats the zone layout of the first
    function automatic logic [4:0] spt(input logic t4040, input logic [7:0] t);
        logic [7:0] s;
        s = (!t4040 && t > 8'd77) ? t - 8'd77 : t;
        if (t4040) return s < 8'd18 ? 5'd21 : s < 8'd25 ? 5'd19 : s < 8'd31 ? 5'd18 : 5'd17;
        return s < 8'd40 ? 5'd29 : s < 8'd54 ? 5'd27 : s < 8'd65 ? 5'd25 : 5'd23;
    endfunction

    state_t      state_q, state_d, after_q, after_d;
    logic        pend_q, pend_d, mtr_q, mtr_d;
    logic        req_drv_q, req_drv_d, res_drv_q, res_drv_d, xdrv_q, xdrv_d;
    logic [7:0]  req_trk_q, req_trk_d, idx_q, idx_d;
    logic [31:0] acc_q, acc_d, nlba_q, nlba_d, res_lba_q, res_lba_d, lba_q, lba_d;
    logic [5:0]  ncnt_q, ncnt_d, res_cnt_q, res_cnt_d, cnt_q, cnt_d;
    logic        res_valid_q, res_valid_d, dirty_q, dirty_d;
    logic        loaded_q, loaded_d, invalid_q, invalid_d, busy_q, busy_d;
    logic [1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [31:0] size_q [0:1];
    logic [31:0] size_d [0:1];

    logic [1:0]  mnt2, ack2;
    logic        mnt_act, trig, ack_x, legal, bad, flush_ok, start;
    logic [4:0]  cnt_t;

    assign mnt2     = 2'(img_mounted);
    assign ack2     = 2'(sd.sd_ack);
    assign mnt_act  = mnt2[drv_act];
    assign trig     = pend_q | mnt_act | (drv_act != req_drv_q) | (track != req_trk_q);
    assign ack_x    = ack2[xdrv_q];
    assign cnt_t    = spt(drv_type, req_trk_q);
    assign legal    = req_trk_q != 8'd0 && req_trk_q <= (drv_type ? 8'd35 : drv_hd ? 8'd154 : 8'd77);
    // Compare in bytes so the partial trailing block of an odd-sized image never counts
    assign bad      = !legal || {acc_q + 32'(cnt_t), 8'd0} > {8'd0, size_q[req_drv_q]};
    assign flush_ok = dirty_q & res_valid_q;

    assign sd.sd_lba     = lba_q;
    assign sd.sd_blk_cnt = cnt_q;
    assign sd.sd_rd      = rd_q[SUBDRV-1:0];
    assign sd.sd_wr      = wr_q[SUBDRV-1:0];
    assign loaded        = loaded_q;
    assign invalid       = invalid_q;
    assign busy          = busy_q;

    // Next-state logic: offset walk, legality check, write-back then read sequencing
    always_comb begin
        state_d     = state_q;
        after_d     = after_q;
        pend_d      = pend_q | mnt_act;
        mtr_d       = mtr;
        req_drv_d   = req_drv_q;
        req_trk_d   = req_trk_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        nlba_d      = nlba_q;
        ncnt_d      = ncnt_q;
        res_drv_d   = res_drv_q;
        res_lba_d   = res_lba_q;
        res_cnt_d   = res_cnt_q;
        res_valid_d = res_valid_q;
        xdrv_d      = xdrv_q;
        dirty_d     = (dirty_q | (buf_we & loaded_q & ~wprot)) & ~mnt2[res_drv_q];
        loaded_d    = loaded_q;
        invalid_d   = invalid_q;
        busy_d      = busy_q;
        lba_d       = lba_q;
        cnt_d       = cnt_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        start       = 1'b0;
        for (int d = 0; d < 2; d++) size_d[d] = (d < SUBDRV && mnt2[d]) ? img_size : size_q[d];
        case (state_q)
            IDLE: begin
                if (trig) start = 1'b1;
                else if (mtr_q && !mtr && flush_ok) begin
                    state_d = WR_REQ;
                    after_d = IDLE;
                    busy_d  = 1'b1;
                    xdrv_d  = res_drv_q;
                    lba_d   = res_lba_q;
                    cnt_d   = res_cnt_q;
                    wr_d    = 2'b01 << res_drv_q;
                end
            end
            CALC: begin
                if (trig) start = 1'b1;
                else if (legal && idx_q < req_trk_q) begin
                    acc_d = acc_q + 32'(spt(drv_type, idx_q));
                    idx_d = idx_q + 8'd1;
                end else state_d = CHECK;
            end
            CHECK: begin
                if (trig) start = 1'b1;
                else begin
                    invalid_d = bad;
                    nlba_d    = acc_q;
                    ncnt_d    = 6'(cnt_t - 5'd1);
                    after_d   = bad ? INVALID : RD_REQ;
                    if (flush_ok) begin
                        state_d = WR_REQ;
                        xdrv_d  = res_drv_q;
                        lba_d   = res_lba_q;
                        cnt_d   = res_cnt_q;
                        wr_d    = 2'b01 << res_drv_q;
                    end else if (bad) begin
                        state_d = INVALID;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = RD_REQ;
                        xdrv_d  = req_drv_q;
                        lba_d   = acc_q;
                        cnt_d   = 6'(cnt_t - 5'd1);
                        rd_d    = 2'b01 << req_drv_q;
                    end
                end
            end
            WR_REQ: begin
                if (ack_x) begin
                    wr_d    = 2'b00;
                    state_d = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (!ack_x) begin
                    dirty_d = 1'b0;
                    if (trig) start = 1'b1;
                    else if (after_q == RD_REQ) begin
                        state_d = RD_REQ;
                        xdrv_d  = req_drv_q;
                        lba_d   = nlba_q;
                        cnt_d   = ncnt_q;
                        rd_d    = 2'b01 << req_drv_q;
                    end else begin
                        state_d = after_q;
                        busy_d  = 1'b0;
                    end
                end
            end
            RD_REQ: begin
                if (ack_x) begin
                    rd_d    = 2'b00;
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (!ack_x) begin
                    res_drv_d   = req_drv_q;
                    res_lba_d   = lba_q;
                    res_cnt_d   = cnt_q;
                    res_valid_d = 1'b1;
                    loaded_d    = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            INVALID: if (trig) start = 1'b1;
            default: state_d = IDLE;
        endcase
        if (start) begin
            state_d   = CALC;
            req_drv_d = drv_act;
            req_trk_d = track;
            acc_d     = 32'd0;
            idx_d     = 8'd1;
            pend_d    = 1'b0;
            busy_d    = 1'b1;
            invalid_d = 1'b0;
        end
        if (trig) loaded_d = 1'b0;
        if (reset) begin
            state_d     = IDLE;
            after_d     = IDLE;
            pend_d      = 1'b1;
            mtr_d       = 1'b0;
            req_drv_d   = 1'b0;
            req_trk_d   = 8'd0;
            idx_d       = 8'd0;
            acc_d       = 32'd0;
            nlba_d      = 32'd0;
            ncnt_d      = 6'd0;
            res_drv_d   = 1'b0;
            res_lba_d   = 32'd0;
            res_cnt_d   = 6'd0;
            res_valid_d = 1'b0;
            xdrv_d      = 1'b0;
            dirty_d     = 1'b0;
            loaded_d    = 1'b0;
            invalid_d   = 1'b0;
            busy_d      = 1'b0;
            lba_d       = 32'd0;
            cnt_d       = 6'd0;
            rd_d        = 2'b00;
            wr_d        = 2'b00;
            for (int d = 0; d < 2; d++) size_d[d] = 32'd0;
        end
    end

    // State register
    always_ff @(posedge clk_sys) begin
        state_q     <= state_d;
        after_q     <= after_d;
        pend_q      <= pend_d;
        mtr_q       <= mtr_d;
        req_drv_q   <= req_drv_d;
        req_trk_q   <= req_trk_d;
        idx_q       <= idx_d;
        acc_q       <= acc_d;
        nlba_q      <= nlba_d;
        ncnt_q      <= ncnt_d;
        res_drv_q   <= res_drv_d;
        res_lba_q   <= res_lba_d;
        res_cnt_q   <= res_cnt_d;
        res_valid_q <= res_valid_d;
        xdrv_q      <= xdrv_d;
        dirty_q     <= dirty_d;
        loaded_q    <= loaded_d;
        invalid_q   <= invalid_d;
        busy_q      <= busy_d;
        lba_q       <= lba_d;
        cnt_q       <= cnt_d;
        rd_q        <= rd_d;
        wr_q        <= wr_d;
        size_q      <= size_d;
    end
endmodule
